// File: rtl/alu_sin_deserializer_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_sin_deserializer_if
// Brief    : Serial input line and decoded-packet result bus between the
//            serial driver (master) and the receive deserializer (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface alu_sin_deserializer_if;

  logic        sin;        // serial line, idle high
  logic        out_valid;  // one-cycle pulse per decoded packet
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  op;
  logic        err_data;
  logic        err_crc;
  logic        err_op;

  // Serial driver side: drives the line and observes decoded results.
  modport master (
    output sin,
    input  out_valid, a, b, op, err_data, err_crc, err_op
  );

  // Deserializer side: samples the line and presents decoded results.
  modport slave (
    input  sin,
    output out_valid, a, b, op, err_data, err_crc, err_op
  );

endinterface
`default_nettype wire

// File: rtl/alu_sin_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : alu_sin_deserializer
// Brief    : Receive-side front end of the serial ALU. Samples sin, decodes
//            11-bit frames (start, ctrl, 8-bit payload, stop), assembles eight
//            data bytes plus one command frame into A, B and op, checks CRC-4,
//            frame count and op legality, and emits one out_valid pulse per
//            packet.
// Revision : 1.0 - initial release
// ============================================================================
module alu_sin_deserializer #(
  parameter int SYNC_STAGES = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  alu_sin_deserializer_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_RX         = 2'd1,
    S_FRAME_DONE = 2'd2
  } state_t;

  localparam logic [3:0] C_BITS_AFTER_START = 4'd9;  // ctrl + 8 payload = 9 shifts, then stop
  localparam logic [3:0] C_FRAMES_PER_PKT   = 4'd8;

  state_t      r_state;
  state_t      w_state_nxt;

  logic        w_sin;
  logic        w_start;     // start bit sampled in IDLE
  logic        w_shift;     // ctrl/payload bit sampled in RX
  logic        w_stop;      // stop bit sampled in RX: frame complete this edge

  logic [3:0]  r_bit_cnt;
  logic [8:0]  r_shift;     // {ctrl, payload[7:0]} once the stop bit arrives
  logic [3:0]  r_frame_cnt;
  logic [63:0] r_ab;        // data bytes of the packet in progress, first byte ends at [63:56]

  logic        r_out_valid;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [2:0]  r_op;
  logic        r_err_data;
  logic        r_err_crc;
  logic        r_err_op;

  logic [3:0]  w_crc_calc;
  logic        w_op_bad;

  // --------------------------------------------------------------------------
  // Optional input synchroniser on sin
  // --------------------------------------------------------------------------
  generate
    if (SYNC_STAGES == 0) begin : g_sync_bypass
      assign w_sin = bus.sin;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] r_sync;

      // Delay line on sin; resets idle-high so reset cannot fabricate a start bit.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_sync <= '1;
        end else begin
          r_sync[0] <= bus.sin;
          for (int i = 1; i < SYNC_STAGES; i++) begin
            r_sync[i] <= r_sync[i-1];
          end
        end
      end

      assign w_sin = r_sync[SYNC_STAGES-1];
    end
  endgenerate

  // --------------------------------------------------------------------------
  // CRC-4, polynomial x^4 + x + 1, init 0, message processed MSB first
  // --------------------------------------------------------------------------
  function automatic logic [3:0] crc4_calc(input logic [67:0] msg);
    logic [3:0] c;
    logic       fb;
    c = 4'd0;
    for (int i = 67; i >= 0; i--) begin
      fb = c[3] ^ msg[i];
      c  = {c[2:0], 1'b0} ^ {2'b00, fb, fb};
    end
    return c;
  endfunction

  // CRC covers the stored operands, a constant 1 marker bit and the received op.
  assign w_crc_calc = crc4_calc({r_ab, 1'b1, r_shift[6:4]});

  // Flag any op outside AND(000), OR(001), ADD(100), SUB(101).
  always_comb begin
    w_op_bad = 1'b1;
    case (r_shift[6:4])
      3'b000, 3'b001, 3'b100, 3'b101: w_op_bad = 1'b0;
      default:                        w_op_bad = 1'b1;
    endcase
  end

  // --------------------------------------------------------------------------
  // Frame FSM
  // --------------------------------------------------------------------------

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and per-edge strobes for the datapath.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_shift     = 1'b0;
    w_stop      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_sin) begin
          w_start     = 1'b1;
          w_state_nxt = S_RX;
        end
      end
      S_RX: begin
        if (r_bit_cnt == 4'd0) begin
          w_stop      = 1'b1;
          w_state_nxt = S_FRAME_DONE;
        end else begin
          w_shift = 1'b1;
        end
      end
      // The frame's result was registered on entry so the pulse is visible
      // during this cycle; the line is ignored here.
      S_FRAME_DONE: w_state_nxt = S_IDLE;
      default:      w_state_nxt = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: bit shifting, packet assembly and result registers
  // --------------------------------------------------------------------------

  // Frame processing happens on the stop-bit edge so results land in FRAME_DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_cnt   <= 4'd0;
      r_shift     <= 9'd0;
      r_frame_cnt <= 4'd0;
      r_ab        <= 64'd0;
      r_out_valid <= 1'b0;
      r_a         <= 32'd0;
      r_b         <= 32'd0;
      r_op        <= 3'd0;
      r_err_data  <= 1'b0;
      r_err_crc   <= 1'b0;
      r_err_op    <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;

      if (w_start) begin
        r_bit_cnt <= C_BITS_AFTER_START;
      end

      if (w_shift) begin
        r_shift   <= {r_shift[7:0], w_sin};
        r_bit_cnt <= r_bit_cnt - 4'd1;
      end

      if (w_stop) begin
        if (!w_sin) begin
          // Framing error: abandon the packet, operands untouched.
          r_out_valid <= 1'b1;
          r_err_data  <= 1'b1;
          r_err_crc   <= 1'b0;
          r_err_op    <= 1'b0;
          r_frame_cnt <= 4'd0;
        end else if (!r_shift[8]) begin
          if (r_frame_cnt == C_FRAMES_PER_PKT) begin
            // Ninth data frame: report and drop it.
            r_out_valid <= 1'b1;
            r_err_data  <= 1'b1;
            r_err_crc   <= 1'b0;
            r_err_op    <= 1'b0;
            r_frame_cnt <= 4'd0;
          end else begin
            // Packets always start at count 0, so shifting places byte n correctly.
            r_ab        <= {r_ab[55:0], r_shift[7:0]};
            r_frame_cnt <= r_frame_cnt + 4'd1;
          end
        end else begin
          r_out_valid <= 1'b1;
          r_frame_cnt <= 4'd0;
          if (r_frame_cnt != C_FRAMES_PER_PKT) begin
            r_err_data <= 1'b1;
            r_err_crc  <= 1'b0;
            r_err_op   <= 1'b0;
          end else begin
            r_err_data <= 1'b0;
            r_err_crc  <= (w_crc_calc != r_shift[3:0]);
            r_err_op   <= w_op_bad;
            r_a        <= r_ab[63:32];
            r_b        <= r_ab[31:0];
            r_op       <= r_shift[6:4];
          end
        end
      end
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.a         = r_a;
  assign bus.b         = r_b;
  assign bus.op        = r_op;
  assign bus.err_data  = r_err_data;
  assign bus.err_crc   = r_err_crc;
  assign bus.err_op    = r_err_op;

endmodule
`default_nettype wire

// File: tb/tb_alu_sin_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_sin_deserializer
// Brief    : Scoreboard bench for alu_sin_deserializer. A packet-level model
//            predicts each out_valid pulse; a monitor pops and compares.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_sin_deserializer;

  localparam int SYNC = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic        ed;
    logic        ec;
    logic        eo;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  exp_t        exp_q[$];
  logic [7:0]  m_bytes[$];
  logic [31:0] m_a = 32'd0;
  logic [31:0] m_b = 32'd0;
  logic [2:0]  m_op = 3'd0;

  alu_sin_deserializer_if bus ();

  alu_sin_deserializer #(.SYNC_STAGES(SYNC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Cycle counter used for latency checks.
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Remainder of (message * x^4) divided by x^4+x+1.
  function automatic logic [3:0] ref_crc(input logic [31:0] ra, input logic [31:0] rb,
                                         input logic [2:0] rop);
    logic [71:0] r;
    r = {ra, rb, 1'b1, rop, 4'b0000};
    for (int i = 71; i >= 4; i--) begin
      if (r[i]) r[i -: 5] = r[i -: 5] ^ 5'b10011;
    end
    return r[3:0];
  endfunction

  function automatic logic [7:0] cmd_byte(input logic [31:0] ca, input logic [31:0] cb,
                                          input logic [2:0] cop);
    return {1'b0, cop, ref_crc(ca, cb, cop)};
  endfunction

  task automatic push_err();
    exp_t e;
    e.a = m_a; e.b = m_b; e.op = m_op;
    e.ed = 1'b1; e.ec = 1'b0; e.eo = 1'b0;
    e.cyc = cyc + 1 + SYNC;
    exp_q.push_back(e);
    m_bytes.delete();
  endtask

  // Packet-level model, called when the stop bit of a frame has just been driven.
  task automatic model_frame(input logic ctrl, input logic [7:0] pay, input logic stop);
    exp_t e;
    if (!stop) begin
      push_err();
    end else if (!ctrl) begin
      if (m_bytes.size() == 8) push_err();
      else m_bytes.push_back(pay);
    end else if (m_bytes.size() != 8) begin
      push_err();
    end else begin
      m_a  = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
      m_b  = {m_bytes[4], m_bytes[5], m_bytes[6], m_bytes[7]};
      m_op = pay[6:4];
      e.a = m_a; e.b = m_b; e.op = m_op;
      e.ed = 1'b0;
      e.ec = (ref_crc(m_a, m_b, m_op) != pay[3:0]);
      e.eo = !(m_op == 3'b000 || m_op == 3'b001 || m_op == 3'b100 || m_op == 3'b101);
      e.cyc = cyc + 1 + SYNC;
      exp_q.push_back(e);
      m_bytes.delete();
    end
  endtask

  task automatic drive_bit(input logic v);
    @(negedge clk);
    bus.sin = v;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_bit(1'b1);
  endtask

  task automatic send_frame(input logic ctrl, input logic [7:0] pay, input logic stop);
    drive_bit(1'b0);
    drive_bit(ctrl);
    for (int i = 7; i >= 0; i--) drive_bit(pay[i]);
    drive_bit(stop);
    model_frame(ctrl, pay, stop);
    drive_bit(1'b1);
  endtask

  task automatic send_data(input int n, input logic [31:0] pa, input logic [31:0] pb);
    logic [63:0] ab;
    ab = {pa, pb};
    for (int i = 0; i < n; i++) send_frame(1'b0, ab[63 - 8*i -: 8], 1'b1);
  endtask

  task automatic send_packet(input logic [31:0] pa, input logic [31:0] pb, input logic [7:0] cmd);
    send_data(8, pa, pb);
    send_frame(1'b1, cmd, 1'b1);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
    chk({tag, "_a"},         64'(bus.a),         64'd0);
    chk({tag, "_b"},         64'(bus.b),         64'd0);
    chk({tag, "_op"},        64'(bus.op),        64'd0);
    chk({tag, "_errs"},      64'({bus.err_data, bus.err_crc, bus.err_op}), 64'd0);
  endtask

  // Monitor: every pulse must match the oldest prediction, including its cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && bus.out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_pulse: out_valid=1 with no pulse expected (cycle %0d)", cyc);
        end else begin
          e = exp_q.pop_front();
          chk("a",        64'(bus.a),        64'(e.a));
          chk("b",        64'(bus.b),        64'(e.b));
          chk("op",       64'(bus.op),       64'(e.op));
          chk("err_data", 64'(bus.err_data), 64'(e.ed));
          chk("err_crc",  64'(bus.err_crc),  64'(e.ec));
          chk("err_op",   64'(bus.err_op),   64'(e.eo));
          chk("latency",  64'(cyc),          64'(e.cyc));
        end
      end
    end
  end

  // Stimulus: directed test-plan packets, then randomized packets.
  initial begin
    logic [31:0] ra, rb;
    logic [2:0]  rop;
    logic [7:0]  cmd;
    int          kind;

    bus.sin = 1'b1;
    rst_n   = 1'b0;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    rst_n = 1'b1;
    idle(3);

    send_packet(32'd0, 32'd0, 8'h0B);
    send_packet(32'd0, 32'd0, 8'h47);
    send_packet(32'd0, 32'd0, 8'h47);
    send_packet(32'd0, 32'd0, 8'h00);
    send_packet(32'd0, 32'd0, 8'h2D);
    send_packet(32'hDEADBEEF, 32'h01234567, cmd_byte(32'hDEADBEEF, 32'h01234567, 3'b101));
    send_data(5, 32'h11223344, 32'h55667788);
    send_frame(1'b1, 8'h0B, 1'b1);
    send_data(8, 32'hA5A5A5A5, 32'h5A5A5A5A);
    send_frame(1'b0, 8'hFF, 1'b1);
    send_data(2, 32'hCAFEF00D, 32'd0);
    send_frame(1'b0, 8'h3C, 1'b0);
    idle(2);

    // Reset in the middle of data frame 6 discards the partial packet.
    send_data(5, 32'h99887766, 32'h55443322);
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    @(negedge clk);
    rst_n   = 1'b0;
    bus.sin = 1'b1;
    m_bytes.delete();
    m_a = 32'd0; m_b = 32'd0; m_op = 3'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_zero_outputs("midreset");
    idle(2);
    send_packet(32'd0, 32'd0, 8'h0B);

    for (int n = 0; n < 40; n++) begin
      ra   = $urandom;
      rb   = $urandom;
      rop  = 3'($urandom_range(0, 7));
      cmd  = cmd_byte(ra, rb, rop);
      kind = $urandom_range(0, 9);
      if (kind <= 5) begin
        send_packet(ra, rb, cmd);
      end else if (kind == 6) begin
        send_packet(ra, rb, cmd ^ {4'b0000, 4'($urandom_range(1, 15))});
      end else if (kind == 7) begin
        send_data($urandom_range(0, 7), ra, rb);
        send_frame(1'b1, cmd, 1'b1);
      end else if (kind == 8) begin
        send_data(8, ra, rb);
        send_frame(1'b0, 8'($urandom), 1'b1);
      end else begin
        send_data($urandom_range(0, 7), ra, rb);
        send_frame(1'($urandom_range(0, 1)), 8'($urandom), 1'b0);
      end
      idle($urandom_range(0, 3));
    end

    idle(30);
    chk("pending_expected", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_sin_deserializer.md
Name: alu_sin_deserializer

Overview:
- Receive-side front end of the serial ALU.
- Samples the `sin` line, decodes 11-bit frames, assembles 8 data frames plus 1 command frame into operands A, B and op, and checks CRC-4, frame count and op legality.
- Presents one result per packet to the ALU core as a single-cycle `out_valid` pulse.
- Sits directly downstream of the testbench serial driver / command monitor.

Parameters:
- SYNC_STAGES, 0, number of flops on `sin` before sampling (0–3); each stage adds one cycle to all latencies.

Ports:
- clk  input  1  clock; all sampling on posedge.
- rst_n  input  1  asynchronous active-low reset.
- sin  input  1  serial input; idle high.
- out_valid  output  1  one-cycle pulse; packet decoded.
- a  output  32  operand A; first data frame is A[31:24].
- b  output  32  operand B; frames 5–8, MSB byte first.
- op  output  3  operation code from the command frame.
- err_data  output  1  frame-count or framing error; valid with `out_valid`.
- err_crc  output  1  CRC mismatch; valid with `out_valid`.
- err_op  output  1  unsupported op; valid with `out_valid`.

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk.
  - All outputs and state are 0 during reset; FSM goes to IDLE and the frame count to 0.
  - Any partial packet is discarded on reset, including mid-frame; no `out_valid` is emitted for it.
- Frame format, MSB first, one bit per clk:
  - bit10 = start (0), bit9 = ctrl (0 data, 1 command), bits8:1 = payload, bit0 = stop (1).
- FSM states: IDLE, RX, FRAME_DONE.
  - IDLE: posedge sampling `sin` = 0 is the start bit; load bit counter = 9; go to RX.
  - RX: shift in `sin` each posedge and decrement the counter; after the stop bit is sampled, go to FRAME_DONE.
  - FRAME_DONE: lasts exactly one cycle; processes the frame, then returns to IDLE.
  - A start bit may be sampled on the cycle after FRAME_DONE, so back-to-back frames are allowed.
- Frame processing:
  - Stop bit = 0: framing error. Emit `out_valid` with err_data=1, err_crc=0, err_op=0; clear the frame count.
  - Data frame with count < 8: store the byte into {A,B} at position count; count += 1.
  - Data frame with count == 8: emit `out_valid` with err_data=1; clear the count. The offending frame is dropped.
  - Command frame with count != 8: emit `out_valid` with err_data=1; clear the count.
  - Command frame with count == 8:
    - Payload is {1'b0, op[2:0], crc[3:0]}.
    - Compute CRC-4 (polynomial x^4+x+1, init 0) over the 68 bits {A, B, 1'b1, op}, processed MSB first.
    - err_crc = (computed != received).
    - err_op = op not in {AND=000, OR=001, ADD=100, SUB=101}.
    - err_crc and err_op may both be set; err_data=0.
    - Emit `out_valid`; clear the count.
- Outputs:
  - `a`, `b` and `op` are registered and update together with the `out_valid` rising edge; they hold until the next pulse.
  - On err_data, `a`/`b`/`op` keep their previous values.
- Latency: with SYNC_STAGES=0, `out_valid` is asserted on the clk cycle after the posedge that sampled the command-frame stop bit.
- `out_valid` is never asserted in two consecutive cycles (the minimum gap is one frame).
- Reset asserted in the same cycle as FRAME_DONE: reset wins; no pulse.

Test Plan:
- A=0, B=0, command byte 0x0B (op AND, crc 0xB):
  - expect one `out_valid` pulse, a=0, b=0, op=000, all err=0;
  - pulse arrives one cycle after the last stop bit.
- A=0, B=0, command byte 0x47 (ADD, crc 0x7), sent back-to-back with a second identical packet -> two pulses, both with no errors.
- A=0, B=0, command byte 0x00 (AND, crc 0x0) -> err_crc=1, err_op=0, err_data=0, op=000.
- A=0, B=0, command byte 0x2D (op 010, crc 0xD) -> err_op=1, err_crc=0, op=010.
- Error-path packets:
  - 5 data frames followed by command 0x0B -> err_data=1 only; `a`/`b` unchanged.
  - 9 data frames -> err_data=1 on the 9th frame.
  - Data frame with stop bit 0 -> err_data=1.
- rst_n pulsed low for 2 cycles in the middle of data frame 6, then a full valid packet (0x0B):
  - no pulse for the aborted packet;
  - exactly one clean pulse for the valid packet.
